ddr4_v2_2_24_tg_pattern_gen_data_bram_seq: RTL and testbench

// Programmable, sequenced BRAM data-pattern source for the DDR4 traffic generator. Host loads

---
 rtl/ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv | 159 +++++++++++++++
 tb/tb_ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv
// rtl/ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv - programmable sequenced BRAM pattern source
//
// Purpose: the host loads pattern words into a DEPTH x DW memory while idle. On a start pulse the
// block streams entries start_ptr..end_ptr (wrapping back to start_ptr, and through DEPTH-1 -> 0
// when end_ptr < start_ptr) over a valid/ready handshake at up to one beat per clk.
//
// Ports:
//   clk, rst              fabric clock, synchronous active-high reset
//   prog_en/addr/data     pattern memory write port (accepted only while idle)
//   start, stop           begin streaming (idle only) / abort streaming (any state)
//   start_ptr, end_ptr    stream bounds, sampled on an accepted start
//   pat_ready             consumer accepts the current beat
//   pat_valid/data/ptr    current beat and the memory address it came from
//   pat_wrap              pulse on the cycle after the end_ptr beat is accepted
//   busy                  high while filling or running
//   prog_err              pulse when a write was dropped because the block was busy
module ddr4_v2_2_24_tg_pattern_gen_data_bram_seq #(
  parameter int TCQ                            = 100,
  parameter int NUM_DQ_PINS                    = 36,
  parameter int nCK_PER_CLK                    = 4,
  parameter int NUM_PORT                       = 1,
  parameter int TG_PATTERN_LOG2_NUM_BRAM_ENTRY = 9,
  localparam int AW    = TG_PATTERN_LOG2_NUM_BRAM_ENTRY,
  localparam int DEPTH = 2 ** AW,
  // TCQ is a simulation-only clk-to-q delay with no effect on logic; it is folded in at zero
  // weight so the parameter remains part of the interface.
  localparam int DW    = NUM_DQ_PINS * 2 * nCK_PER_CLK * NUM_PORT + 0 * TCQ
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_en,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_ptr,
  input  logic [AW-1:0] end_ptr,
  input  logic          pat_ready,
  output logic          pat_valid,
  output logic [DW-1:0] pat_data,
  output logic [AW-1:0] pat_ptr,
  output logic          pat_wrap,
  output logic          busy,
  output logic          prog_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rd_q;  // BRAM read register, also the newer of the two buffer slots

  state_t        state_q,     state_d;
  logic [AW-1:0] start_ptr_q, start_ptr_d;
  logic [AW-1:0] end_ptr_q,   end_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic          rd_vld_q,    rd_vld_d;
  logic [AW-1:0] rd_addr_q,   rd_addr_d;
  logic          sk_vld_q,    sk_vld_d;
  logic [DW-1:0] sk_data_q,   sk_data_d;
  logic [AW-1:0] sk_ptr_q,    sk_ptr_d;
  logic          pat_wrap_q,  pat_wrap_d;
  logic          prog_err_q,  prog_err_d;

  logic accept, sk_keep, rd_keep, rd_en;

  always_comb begin
    busy      = (state_q != ST_IDLE);
    // The skid slot always holds the older beat, so it is presented first.
    pat_valid = sk_vld_q | rd_vld_q;
    pat_data  = sk_vld_q ? sk_data_q : (rd_vld_q ? mem_rd_q  : '0);
    pat_ptr   = sk_vld_q ? sk_ptr_q  : (rd_vld_q ? rd_addr_q : '0);
    pat_wrap  = pat_wrap_q;
    prog_err  = prog_err_q;

    accept  = pat_valid & pat_ready & ~stop;
    sk_keep = sk_vld_q & ~accept;
    rd_keep = rd_vld_q & ~(accept & ~sk_vld_q);
    // Prefetch whenever a slot will be free after this cycle's pop; the 1-cycle read lands
    // in mem_rd_q, so a read in flight and an occupied rd slot are the same thing.
    rd_en   = busy & ~stop & ~(sk_keep & rd_keep);

    state_d     = state_q;
    start_ptr_d = start_ptr_q;
    end_ptr_d   = end_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_vld_d    = rd_keep;
    rd_addr_d   = rd_addr_q;
    sk_vld_d    = sk_keep;
    sk_data_d   = sk_data_q;
    sk_ptr_d    = sk_ptr_q;
    pat_wrap_d  = accept & (pat_ptr == end_ptr_q);
    prog_err_d  = prog_en & busy;

    if (rd_en) begin
      rd_ptr_d  = (rd_ptr_q == end_ptr_q) ? start_ptr_q : rd_ptr_q + AW'(1);
      rd_addr_d = rd_ptr_q;
      rd_vld_d  = 1'b1;
      // An unconsumed beat in mem_rd_q is about to be overwritten: shift it to the skid slot.
      if (rd_keep) begin
        sk_vld_d  = 1'b1;
        sk_data_d = mem_rd_q;
        sk_ptr_d  = rd_addr_q;
      end
    end

    case (state_q)
      ST_IDLE: if (start && !stop) begin
        state_d     = ST_FILL;
        start_ptr_d = start_ptr;
        end_ptr_d   = end_ptr;
        rd_ptr_d    = start_ptr;
      end
      ST_FILL: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    if (stop) begin
      state_d    = ST_IDLE;
      rd_vld_d   = 1'b0;
      sk_vld_d   = 1'b0;
      pat_wrap_d = 1'b0;
    end
  end

  // Memory and its read register carry no reset so they map onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (prog_en && state_q == ST_IDLE) mem[prog_addr] <= prog_data;
    if (rd_en) mem_rd_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_ptr_q <= '0;
      end_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      sk_vld_q    <= 1'b0;
      sk_data_q   <= '0;
      sk_ptr_q    <= '0;
      pat_wrap_q  <= 1'b0;
      prog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_ptr_q <= start_ptr_d;
      end_ptr_q   <= end_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      sk_vld_q    <= sk_vld_d;
      sk_data_q   <= sk_data_d;
      sk_ptr_q    <= sk_ptr_d;
      pat_wrap_q  <= pat_wrap_d;
      prog_err_q  <= prog_err_d;
    end
  end

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv
// tb/tb_ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv - self-checking bench for the BRAM pattern source
module tb_ddr4_v2_2_24_tg_pattern_gen_data_bram_seq;

  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int DW    = 288;

  logic          clk = 1'b0;
  logic          rst, prog_en, start, stop, pat_ready;
  logic [AW-1:0] prog_addr, start_ptr, end_ptr;
  logic [DW-1:0] prog_data;
  logic          pat_valid, pat_wrap, busy, prog_err;
  logic [DW-1:0] pat_data;
  logic [AW-1:0] pat_ptr;

  logic [DW-1:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  ddr4_v2_2_24_tg_pattern_gen_data_bram_seq dut (
    .clk(clk), .rst(rst), .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .stop(stop), .start_ptr(start_ptr), .end_ptr(end_ptr), .pat_ready(pat_ready),
    .pat_valid(pat_valid), .pat_data(pat_data), .pat_ptr(pat_ptr), .pat_wrap(pat_wrap),
    .busy(busy), .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic prog(input int addr, input logic [DW-1:0] data);
    prog_en   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = data;
    step();
    prog_en   = 1'b0;
    ref_mem[addr] = data;
  endtask

  // Streams sp..ep for ncyc cycles after the first beat, then ends with stop (kind 0) or rst (kind 1).
  task automatic run_stream(input int sp, input int ep, input int ncyc, input int mode,
                            input int prog_cycle, input int kind);
    int            exp_ptr  = sp;
    bit            wrap_exp = 1'b0;
    bit            err_exp  = 1'b0;
    bit            prev_v   = 1'b0;
    bit            prev_r   = 1'b0;
    logic [DW-1:0] prev_d   = '0;
    logic [AW-1:0] prev_p   = '0;

    start = 1'b1; start_ptr = AW'(sp); end_ptr = AW'(ep); pat_ready = 1'($urandom);
    @(negedge clk);
    check("t0_valid", pat_valid, 0);
    check("t0_busy", busy, 0);
    step();
    start = 1'b0; start_ptr = AW'($urandom); end_ptr = AW'($urandom); pat_ready = 1'($urandom);
    @(negedge clk);
    check("t1_valid", pat_valid, 0);
    check("t1_busy", busy, 1);
    step();

    for (int c = 0; c < ncyc; c++) begin
      case (mode)
        0:       pat_ready = 1'b1;
        1:       pat_ready = (c % 4 == 0) || (c % 4 == 3);
        default: pat_ready = 1'($urandom);
      endcase
      prog_en   = (c == prog_cycle);
      prog_addr = AW'(sp);
      prog_data = rand_word();
      @(negedge clk);
      if (c == 0)      check("first_valid", pat_valid, 1);
      else if (prev_v) check("valid_kept", pat_valid, 1);
      check("wrap", pat_wrap, wrap_exp);
      check("prog_err", prog_err, err_exp);
      if (prev_v && !prev_r) begin
        check("hold_data", pat_data, prev_d);
        check("hold_ptr", pat_ptr, prev_p);
      end
      wrap_exp = 1'b0;
      if (pat_valid && pat_ready) begin
        check("ptr", pat_ptr, exp_ptr);
        check("data", pat_data, ref_mem[exp_ptr]);
        wrap_exp = (exp_ptr == ep);
        exp_ptr  = (exp_ptr == ep) ? sp : (exp_ptr + 1) % DEPTH;
      end
      err_exp = prog_en;
      prev_v = pat_valid; prev_r = pat_ready; prev_d = pat_data; prev_p = pat_ptr;
      step();
    end
    prog_en = 1'b0;

    if (kind == 0) begin stop = 1'b1; start = 1'b1; end
    else rst = 1'b1;
    pat_ready = 1'($urandom);
    step();
    stop = 1'b0; start = 1'b0; rst = 1'b0; pat_ready = 1'b0;
    @(negedge clk);
    check("end_valid", pat_valid, 0);
    check("end_busy", busy, 0);
    if (kind == 1) begin
      check("rst_data", pat_data, 0);
      check("rst_ptr", pat_ptr, 0);
      check("rst_wrap", pat_wrap, 0);
      check("rst_err", prog_err, 0);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; prog_en = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; stop = 1'b0;
    start_ptr = '0; end_ptr = '0; pat_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("reset_valid", pat_valid, 0);
    check("reset_data", pat_data, 0);
    check("reset_ptr", pat_ptr, 0);
    check("reset_wrap", pat_wrap, 0);
    check("reset_busy", busy, 0);
    check("reset_err", prog_err, 0);
    step();
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) prog(a, rand_word());
    prog(0, DW'('h123)); prog(1, DW'('h456)); prog(2, DW'('h789)); prog(3, DW'('h0AB));
    @(negedge clk);
    check("idle_prog_err", prog_err, 0);
    step();

    run_stream(0, 3, 20, 0, -1, 0);
    run_stream(0, 3, 24, 1, -1, 0);
    run_stream(DEPTH - 2, 1, 20, 2, -1, 0);
    run_stream(5, 5, 12, 2, -1, 0);
    run_stream(100, 107, 30, 2, 7, 0);
    run_stream(100, 107, 12, 0, -1, 0);

    // stop together with start in idle must not launch a stream
    stop = 1'b1; start = 1'b1; start_ptr = AW'(9); end_ptr = AW'(12);
    step();
    stop = 1'b0; start = 1'b0;
    @(negedge clk);
    check("stop_start_busy", busy, 0);
    step();
    @(negedge clk);
    check("stop_start_valid", pat_valid, 0);
    step();

    run_stream(20, 30, 15, 2, -1, 1);
    run_stream(20, 30, 15, 0, -1, 0);

    for (int i = 0; i < 4; i++)
      run_stream(int'($urandom_range(DEPTH - 1)), int'($urandom_range(DEPTH - 1)), 40, 2, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
